// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit slice.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  localparam logic MEM_SIZE_BYTE = 1'b0;
  localparam logic MEM_SIZE_WORD = 1'b1;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLL  = 4'd6,
    ALU_SRL  = 4'd7
  } alu_ops_t;

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte-lane steering for the LSU: byte enables, replicated store data and
// sign-extended byte load data.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [1:0]  addr,
  input  logic        size,
  input  logic [31:0] wdata,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  sel,
  output logic [31:0] dat_o,
  output logic [31:0] rdata_ext
);

  logic [7:0] lane;

  always_comb begin
    unique case (addr)
      2'd0:    lane = bus_rdata[7:0];
      2'd1:    lane = bus_rdata[15:8];
      2'd2:    lane = bus_rdata[23:16];
      default: lane = bus_rdata[31:24];
    endcase

    if (size == MEM_SIZE_WORD) begin
      sel       = 4'hF;
      dat_o     = wdata;
      rdata_ext = bus_rdata;
    end else begin
      sel       = 4'b0001 << addr;
      dat_o     = {4{wdata[7:0]}};
      rdata_ext = {{24{lane[7]}}, lane};
    end
  end

endmodule

// File: rtl/lsu_bus_master.sv
// Executes one load/store as a single Wishbone classic cycle with ack timeout.
// Optional: LSU_MISALIGN_CHECK_EN rejects word accesses with addr[1:0] != 0.
module lsu_bus_master #(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemSize,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic        wb_ack_i,
  input  logic [31:0] wb_dat_i
);

  import lsu_pkg::*;

  localparam int unsigned TW = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT + 1) : 1;

  lsu_state_t  state_q, state_d;
  logic [TW-1:0] tmo_cnt;
  logic        load_q;
  logic        size_q;
  logic [1:0]  addr_lo_q;
  logic        err_q;
  logic [31:0] rdata_q;

  logic        accept, illegal, noop, misalign, bypass, tmo_hit;
  logic [1:0]  lane_addr;
  logic        lane_size;
  logic [3:0]  lane_sel;
  logic [31:0] lane_dat;
  logic [31:0] lane_rdata;

  // Steering uses the live request while idle and the latched fields once on the bus.
  assign lane_addr = (state_q == IDLE) ? req_addr[1:0] : addr_lo_q;
  assign lane_size = (state_q == IDLE) ? MemSize : size_q;

  lsu_byte_lane u_lane (
    .addr      (lane_addr),
    .size      (lane_size),
    .wdata     (req_wdata),
    .bus_rdata (wb_dat_i),
    .sel       (lane_sel),
    .dat_o     (lane_dat),
    .rdata_ext (lane_rdata)
  );

  assign req_ready = (state_q == IDLE) && !reset;
  assign rsp_valid = (state_q == DONE);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign wb_stb_o  = wb_cyc_o;

  always_comb begin
    accept  = req_valid && req_ready;
    illegal = MemRead && MemWrite;
    noop    = !MemRead && !MemWrite;
`ifdef LSU_MISALIGN_CHECK_EN
    misalign = (MemSize == MEM_SIZE_WORD) && (req_addr[1:0] != 2'b00);
`else
    misalign = 1'b0;
`endif
    bypass  = illegal || noop || misalign;
    // Counter holds the number of elapsed non-ack cycles; abort on the last allowed one.
    tmo_hit = (BUS_TIMEOUT != 0) && (tmo_cnt == TW'(BUS_TIMEOUT - 1));

    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = bypass ? DONE : BUS;
      BUS:     if (wb_ack_i || tmo_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt   <= '0;
      load_q    <= 1'b0;
      size_q    <= 1'b0;
      addr_lo_q <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      wb_cyc_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_adr_o  <= '0;
      wb_dat_o  <= '0;
      wb_sel_o  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            tmo_cnt   <= '0;
            load_q    <= MemRead;
            size_q    <= MemSize;
            addr_lo_q <= req_addr[1:0];
            err_q     <= illegal || misalign;
            rdata_q   <= '0;
            if (!bypass) begin
              wb_cyc_o <= 1'b1;
              wb_we_o  <= MemWrite;
              wb_adr_o <= {req_addr[31:2], 2'b00};
              wb_dat_o <= lane_dat;
              wb_sel_o <= lane_sel;
            end
          end
        end
        BUS: begin
          if (wb_ack_i || tmo_hit) begin
            wb_cyc_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            wb_sel_o <= '0;
            if (wb_ack_i) rdata_q <= load_q ? lane_rdata : '0;
            else          err_q   <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        DONE: begin
          err_q   <= 1'b0;
          rdata_q <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_bus_master.sv
// Randomized self-checking bench for lsu_bus_master against a transaction-level model.
module tb_lsu_bus_master;

  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic        MemRead, MemWrite, MemSize;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i;
  logic [31:0] wb_dat_i;

  int unsigned vec_cnt = 0;
  int unsigned err_cnt = 0;

  lsu_bus_master #(.BUS_TIMEOUT(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .MemSize   (MemSize),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .wb_cyc_o  (wb_cyc_o),
    .wb_stb_o  (wb_stb_o),
    .wb_we_o   (wb_we_o),
    .wb_adr_o  (wb_adr_o),
    .wb_dat_o  (wb_dat_o),
    .wb_sel_o  (wb_sel_o),
    .wb_ack_i  (wb_ack_i),
    .wb_dat_i  (wb_dat_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the response.
  task automatic run_txn(input logic rd, input logic wr, input logic sz,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int unsigned ack_dly, input logic fix_dat,
                         input logic [31:0] dat);
    logic        misal, bypass, done, exp_err;
    logic [31:0] exp_sel, exp_dat, exp_rdata, ack_dat, b;
    int unsigned exp_bus, nbus, k;

    misal = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
    misal = sz && (addr[1:0] != 2'b00);
`endif
    bypass  = (rd && wr) || (!rd && !wr) || misal;
    exp_sel = sz ? 32'hF : (32'd1 << addr[1:0]);
    exp_dat = sz ? wdata : (32'(wdata[7:0]) * 32'h0101_0101);

    check("ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; MemRead = rd; MemWrite = wr; MemSize = sz;
    req_addr = addr; req_wdata = wdata;

    nbus = 0; k = 0; done = 1'b0; ack_dat = '0;
    while (!done && k < 300) begin
      @(negedge clk);
      k++;
      req_valid = 1'($urandom_range(0, 1));
      MemRead   = 1'($urandom_range(0, 1));
      MemWrite  = 1'($urandom_range(0, 1));
      MemSize   = 1'($urandom_range(0, 1));
      req_addr  = $urandom;
      req_wdata = $urandom;
      if (rsp_valid) begin
        done      = 1'b1;
        req_valid = 1'b0;
        wb_ack_i  = 1'($urandom_range(0, 1));
        wb_dat_i  = $urandom;
      end else begin
        check("ready_busy", 32'(req_ready), 32'd0);
        if (wb_cyc_o) begin
          nbus++;
          check("stb_eq_cyc", 32'(wb_stb_o), 32'd1);
          check("adr", wb_adr_o, {addr[31:2], 2'b00});
          check("sel", 32'(wb_sel_o), exp_sel);
          check("we", 32'(wb_we_o), 32'(wr));
          if (wr) check("dat_o", wb_dat_o, exp_dat);
          wb_ack_i = (nbus - 1 == ack_dly);
          wb_dat_i = fix_dat ? dat : $urandom;
          if (wb_ack_i) ack_dat = wb_dat_i;
        end else begin
          wb_ack_i = 1'($urandom_range(0, 1));
          wb_dat_i = $urandom;
        end
      end
    end

    exp_bus = bypass ? 0 : ((ack_dly < TMO) ? ack_dly + 1 : TMO);
    exp_err = (rd && wr) || misal || (!bypass && ack_dly >= TMO);
    exp_rdata = '0;
    if (!bypass && rd && ack_dly < TMO) begin
      if (sz) exp_rdata = ack_dat;
      else begin
        b = (ack_dat >> (8 * addr[1:0])) & 32'hFF;
        exp_rdata = (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      end
    end

    check("rsp_seen", 32'(done), 32'd1);
    check("rsp_err", 32'(rsp_err), 32'(exp_err));
    check("rsp_rdata", rsp_rdata, exp_rdata);
    check("bus_cycles", nbus, exp_bus);
    check("latency", k, exp_bus + 1);

    @(negedge clk);
    wb_ack_i = 1'b0;
    check("rsp_one_cycle", 32'(rsp_valid), 32'd0);
    check("ready_after", 32'(req_ready), 32'd1);
    check("cyc_after", 32'(wb_cyc_o), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; MemSize = 1'b0;
    req_addr = '0; req_wdata = '0; wb_ack_i = 1'b0; wb_dat_i = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_cyc", 32'(wb_cyc_o), 32'd0);
    check("rst_rsp", 32'(rsp_valid), 32'd0);
    check("rst_sel", 32'(wb_sel_o), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_txn(1'b0, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 0, 1'b0, 32'h0);
    run_txn(1'b1, 1'b0, 1'b0, 32'h103, 32'h0, 0, 1'b1, 32'h80FF_0000);
    run_txn(1'b1, 1'b0, 1'b1, 32'h104, 32'h0, 100, 1'b0, 32'h0);
    run_txn(1'b1, 1'b0, 1'b1, 32'h102, 32'h0, 1, 1'b1, 32'h1234_5678);
    run_txn(1'b1, 1'b1, 1'b1, 32'h200, 32'h5555_AAAA, 0, 1'b0, 32'h0);
    run_txn(1'b0, 1'b0, 1'b0, 32'h300, 32'h0, 0, 1'b0, 32'h0);
    run_txn(1'b0, 1'b1, 1'b0, 32'h401, 32'h0000_00A5, 2, 1'b0, 32'h0);
    run_txn(1'b0, 1'b1, 1'b0, 32'h402, 32'h0000_003C, 3, 1'b0, 32'h0);

    // Reset while a load is waiting on the bus.
    req_valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; MemSize = 1'b1; req_addr = 32'h200;
    @(negedge clk);
    req_valid = 1'b0; wb_ack_i = 1'b0;
    check("rstbus_cyc_pre", 32'(wb_cyc_o), 32'd1);
    #2 reset = 1'b1; wb_ack_i = 1'b1;
    #1;
    check("rstbus_cyc", 32'(wb_cyc_o), 32'd0);
    check("rstbus_stb", 32'(wb_stb_o), 32'd0);
    check("rstbus_rsp", 32'(rsp_valid), 32'd0);
    check("rstbus_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("rstbus_rsp2", 32'(rsp_valid), 32'd0);
    reset = 1'b0;
    #1;
    check("rstbus_ready_rel", 32'(req_ready), 32'd1);
    @(negedge clk);
    check("rstbus_rsp3", 32'(rsp_valid), 32'd0);
    check("rstbus_cyc3", 32'(wb_cyc_o), 32'd0);
    wb_ack_i = 1'b0;

    for (int i = 0; i < 150; i++) begin
      int unsigned op, dly;
      logic r, w;
      op = $urandom_range(0, 7);
      r = (op == 0) || (op >= 2 && op <= 4);
      w = (op == 0) || (op >= 5);
      dly = ($urandom_range(0, 7) == 0) ? 6 : $urandom_range(0, 3);
      run_txn(r, w, 1'($urandom_range(0, 1)), $urandom, $urandom, dly, 1'b0, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
